// File: rtl/alu_bypass_responder.sv
// Responder side of the ALU issue stage bypass-buffer operand request.
// Optional: define ALU_BYPASS_WB_FORWARD_EN to forward same-cycle writebacks into waiting sides.
module alu_bypass_responder #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Drive_1,
  output logic              o_Free_1,
  input  logic [TAG_W-1:0]  i_DepL_4,
  input  logic [TAG_W-1:0]  i_DepR_4,
  output logic              o_DriveL_1,
  input  logic              i_FreeL_1,
  output logic [DATA_W-1:0] o_DataL_32,
  output logic              o_DriveR_1,
  input  logic              i_FreeR_1,
  output logic [DATA_W-1:0] o_DataR_32,
  input  logic              i_AllocValid_1,
  input  logic [TAG_W-1:0]  i_AllocTag_4,
  input  logic              i_WbValid_1,
  input  logic [TAG_W-1:0]  i_WbTag_4,
  input  logic [DATA_W-1:0] i_WbData_32,
  input  logic              i_Flush_1
);

  // One slot per tag value; the all-ones slot is never written so it reads as invalid.
  localparam int              NUM_SLOTS = 2**TAG_W;
  localparam logic [TAG_W-1:0] NONE_TAG  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    free_q, free_d;
  logic [NUM_SLOTS-1:0]    valid_q, valid_d;
  logic [DATA_W-1:0]       data_q [NUM_SLOTS];
  logic [DATA_W-1:0]       data_d [NUM_SLOTS];
  logic [TAG_W-1:0]        dep_q [2];
  logic [TAG_W-1:0]        dep_d [2];
  logic [DATA_W-1:0]       rsp_q [2];
  logic [DATA_W-1:0]       rsp_d [2];
  logic [1:0]              drv_q, drv_d;
  logic [1:0]              done_q, done_d;

  logic [TAG_W-1:0]        dep_in [2];
  logic [TAG_W-1:0]        req_tag [2];
  logic [DATA_W-1:0]       side_data [2];
  logic [1:0]              free_in;
  logic [1:0]              fwd_hit;
  logic [1:0]              side_hit;

  assign dep_in[0] = i_DepL_4;
  assign dep_in[1] = i_DepR_4;
  assign free_in   = {i_FreeR_1, i_FreeL_1};

  function automatic state_e wait_state(input logic [1:0] done);
    if (&done)      return ST_IDLE;
    else if (|done) return ST_DONE_WAIT;
    else            return ST_WAIT;
  endfunction

  // In IDLE the incoming request tags are looked up so a ready entry drives one cycle after accept.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      req_tag[s] = (state_q == ST_IDLE) ? dep_in[s] : dep_q[s];
`ifdef ALU_BYPASS_WB_FORWARD_EN
      fwd_hit[s] = i_WbValid_1 && (i_WbTag_4 == req_tag[s]) &&
                   !(i_AllocValid_1 && (i_AllocTag_4 == req_tag[s]));
`else
      fwd_hit[s] = 1'b0;
`endif
      side_hit[s]  = (req_tag[s] != NONE_TAG) && (valid_q[req_tag[s]] || fwd_hit[s]);
      side_data[s] = valid_q[req_tag[s]] ? data_q[req_tag[s]] : i_WbData_32;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < NUM_SLOTS - 1; i++) begin
      if (i_Flush_1) begin
        valid_d[i] = 1'b0;
      end else if (i_AllocValid_1 && (i_AllocTag_4 == TAG_W'(i))) begin
        valid_d[i] = 1'b0;
      end else if (i_WbValid_1 && (i_WbTag_4 == TAG_W'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = i_WbData_32;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dep_d   = dep_q;
    rsp_d   = rsp_q;
    drv_d   = drv_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Drive_1) begin
          for (int s = 0; s < 2; s++) begin
            dep_d[s]  = dep_in[s];
            done_d[s] = (dep_in[s] == NONE_TAG);
            if (side_hit[s]) begin
              drv_d[s] = 1'b1;
              rsp_d[s] = side_data[s];
            end
          end
          state_d = wait_state(done_d);
        end
      end
      default: begin
        for (int s = 0; s < 2; s++) begin
          if (drv_q[s]) begin
            if (free_in[s]) begin
              drv_d[s]  = 1'b0;
              done_d[s] = 1'b1;
            end
          end else if (!done_q[s] && side_hit[s]) begin
            drv_d[s] = 1'b1;
            rsp_d[s] = side_data[s];
          end
        end
        state_d = wait_state(done_d);
      end
    endcase

    if (i_Flush_1) begin
      state_d = ST_IDLE;
      drv_d   = '0;
      done_d  = '0;
    end

    free_d = (state_d == ST_IDLE);
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      free_q  <= 1'b1;
      valid_q <= '0;
      drv_q   <= '0;
      done_q  <= '0;
      // NOTE: the result table is cleared on reset because its data is defined as zero out of reset.
      for (int i = 0; i < NUM_SLOTS; i++) data_q[i] <= '0;
      for (int s = 0; s < 2; s++) begin
        dep_q[s] <= '0;
        rsp_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dep_q   <= dep_d;
      rsp_q   <= rsp_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
    end
  end

  // Ready is held low for the whole reset and rises in the very first cycle after it.
  assign o_Free_1   = free_q & ~rst;
  assign o_DriveL_1 = drv_q[0];
  assign o_DriveR_1 = drv_q[1];
  assign o_DataL_32 = rsp_q[0];
  assign o_DataR_32 = rsp_q[1];

endmodule

// File: tb/tb_alu_bypass_responder.sv
// Scoreboard bench for alu_bypass_responder: stimulus queues expected drives, a monitor checks them.
module tb_alu_bypass_responder;

`ifdef ALU_BYPASS_WB_FORWARD_EN
  localparam int WB_LAT = 1;
`else
  localparam int WB_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        drive, free_l, free_r, alloc_v, wb_v, flush;
  logic [3:0]  dep_l, dep_r, alloc_tag, wb_tag;
  logic [31:0] wb_data;
  logic        o_free, drv_l, drv_r;
  logic [31:0] data_l, data_r;

  alu_bypass_responder #(.DATA_W(32), .TAG_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_Drive_1      (drive),
    .o_Free_1       (o_free),
    .i_DepL_4       (dep_l),
    .i_DepR_4       (dep_r),
    .o_DriveL_1     (drv_l),
    .i_FreeL_1      (free_l),
    .o_DataL_32     (data_l),
    .o_DriveR_1     (drv_r),
    .i_FreeR_1      (free_r),
    .o_DataR_32     (data_r),
    .i_AllocValid_1 (alloc_v),
    .i_AllocTag_4   (alloc_tag),
    .i_WbValid_1    (wb_v),
    .i_WbTag_4      (wb_tag),
    .i_WbData_32    (wb_data),
    .i_Flush_1      (flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q_l[$];
  exp_t        q_r[$];
  logic        prev_drv [2];
  logic        pend     [2];
  logic [31:0] held     [2];

  task automatic mon_side(input int s, input logic drv, input logic [31:0] data, input logic free);
    exp_t e;
    logic empty;
    if (pend[s])
      check((s == 0) ? "L drop after free" : "R drop after free", {31'b0, drv}, 32'h0);
    if (drv && !prev_drv[s]) begin
      empty = (s == 0) ? (q_l.size() == 0) : (q_r.size() == 0);
      if (empty) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s unexpected drive: got data %h, expected no drive (cycle %0d)",
                 (s == 0) ? "L" : "R", data, cyc);
      end else begin
        if (s == 0) e = q_l.pop_front();
        else        e = q_r.pop_front();
        check((s == 0) ? "L data" : "R data", data, e.data);
        check((s == 0) ? "L drive cycle" : "R drive cycle", cyc, e.cyc);
      end
      held[s] = data;
    end else if (drv) begin
      check((s == 0) ? "L data held" : "R data held", data, held[s]);
    end
    pend[s]     = drv && free;
    prev_drv[s] = drv;
  endtask

  // Monitor samples on the falling edge, midway between input changes and DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        prev_drv[s] = 1'b0;
        pend[s]     = 1'b0;
      end
    end else begin
      mon_side(0, drv_l, data_l, free_l);
      mon_side(1, drv_r, data_r, free_r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    drive   = 1'b0;
    free_l  = 1'b0;
    free_r  = 1'b0;
    alloc_v = 1'b0;
    wb_v    = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] l, input logic [3:0] r);
    drive = 1'b1;
    dep_l = l;
    dep_r = r;
  endtask

  task automatic set_wb(input logic [3:0] t, input logic [31:0] d);
    wb_v    = 1'b1;
    wb_tag  = t;
    wb_data = d;
  endtask

  task automatic set_alloc(input logic [3:0] t);
    alloc_v   = 1'b1;
    alloc_tag = t;
  endtask

  task automatic push_l(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q_l.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q_r.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " free"},  {31'b0, o_free}, 32'h0);
    check({tag, " drvL"},  {31'b0, drv_l},  32'h0);
    check({tag, " drvR"},  {31'b0, drv_r},  32'h0);
    check({tag, " dataL"}, data_l,          32'h0);
    check({tag, " dataR"}, data_r,          32'h0);
  endtask

  initial begin
    int n;
    int m;
    rst = 1'b1;
    drive = 1'b0; free_l = 1'b0; free_r = 1'b0; alloc_v = 1'b0; wb_v = 1'b0; flush = 1'b0;
    dep_l = '0; dep_r = '0; alloc_tag = '0; wb_tag = '0; wb_data = '0;

    tick();
    tick();
    check_reset_outputs("in reset");
    rst = 1'b0;
    #1;
    check("free after reset", {31'b0, o_free}, 32'h1);

    // Request on an invalid entry waits without driving; flush returns to idle.
    set_req(4'd3, 4'hF);
    tick();
    repeat (4) tick();
    check("free while waiting", {31'b0, o_free}, 32'h0);
    flush = 1'b1;
    tick();
    check("free after flush", {31'b0, o_free}, 32'h1);

    // Both entries valid: drives together, data frozen against a later writeback.
    set_wb(4'd3, 32'hDEADBEEF);
    tick();
    set_wb(4'd5, 32'h12345678);
    tick();
    tick();
    set_req(4'd3, 4'd5);
    n = cyc;
    push_l(32'hDEADBEEF, n + 1);
    push_r(32'h12345678, n + 1);
    tick();
    set_wb(4'd3, 32'h00000001);
    tick();
    free_l = 1'b1;
    tick();
    tick();
    check("free before last release", {31'b0, o_free}, 32'h0);
    free_r = 1'b1;
    tick();
    check("free after both released", {31'b0, o_free}, 32'h1);

    // Same tag on both sides, released together.
    set_wb(4'd2, 32'hCAFEF00D);
    tick();
    set_req(4'd2, 4'd2);
    n = cyc;
    push_l(32'hCAFEF00D, n + 1);
    push_r(32'hCAFEF00D, n + 1);
    tick();
    free_l = 1'b1;
    free_r = 1'b1;
    tick();
    check("free after same-tag release", {31'b0, o_free}, 32'h1);

    // Flush coinciding with accept drops the request.
    set_req(4'd2, 4'hF);
    flush = 1'b1;
    tick();
    check("free flush over accept", {31'b0, o_free}, 32'h1);
    repeat (3) tick();

    // Entries written before the flush must now be invalid.
    set_req(4'd5, 4'd3);
    tick();
    repeat (4) tick();
    check("free stale entries invalid", {31'b0, o_free}, 32'h0);
    flush = 1'b1;
    tick();

    // Allocated entry: only the left side drives once the writeback lands.
    set_alloc(4'd7);
    tick();
    set_req(4'd7, 4'hF);
    tick();
    tick();
    tick();
    set_wb(4'd7, 32'hA5A5A5A5);
    m = cyc;
    push_l(32'hA5A5A5A5, m + WB_LAT);
    tick();
    repeat (WB_LAT - 1) tick();
    free_l = 1'b1;
    tick();
    check("free after alloc/wb release", {31'b0, o_free}, 32'h1);

    // Writeback coinciding with accept on an invalid entry.
    set_wb(4'd11, 32'h0BADF00D);
    set_req(4'd11, 4'hF);
    n = cyc;
    push_l(32'h0BADF00D, n + WB_LAT);
    tick();
    repeat (WB_LAT - 1) tick();
    free_l = 1'b1;
    tick();
    check("free after accept-time wb", {31'b0, o_free}, 32'h1);

    // Alloc beats a same-cycle writeback, both before and during a wait.
    set_alloc(4'd9);
    set_wb(4'd9, 32'h99999999);
    tick();
    set_req(4'd9, 4'hF);
    tick();
    set_alloc(4'd9);
    set_wb(4'd9, 32'h88888888);
    tick();
    repeat (4) tick();
    check("free alloc beats wb", {31'b0, o_free}, 32'h0);
    flush = 1'b1;
    tick();

    // No dependency on either side: no transaction at all.
    set_req(4'hF, 4'hF);
    tick();
    check("free both none", {31'b0, o_free}, 32'h1);
    tick();
    check("free both none later", {31'b0, o_free}, 32'h1);

    // Reset while a side is being driven aborts the transaction.
    set_wb(4'd4, 32'h44444444);
    tick();
    set_req(4'd4, 4'hF);
    n = cyc;
    push_l(32'h44444444, n + 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("mid-txn reset");
    rst = 1'b0;
    #1;
    check("free after mid-txn reset", {31'b0, o_free}, 32'h1);
    repeat (3) tick();
    check("dataL after mid-txn reset", data_l, 32'h0);

    check("pending L expectations", q_l.size(), 32'h0);
    check("pending R expectations", q_r.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_bypass_responder.md
Name: alu_bypass_responder

Overview:
- Responder side of the ALU issue stage's bypass-buffer operand request.
- Holds one result entry per in-flight producer tag, written by ALU writeback.
- Accepts a left/right dependency-tag request from the issue stage and returns each operand on its own drive/free handshake once the producer result is valid.
- Tag 4'b1111 means "no dependency". That side gets no response and is served by the GRF path instead.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 4, dependency tag width; entries = 2**TAG_W-1 (tags 0..14); all-ones tag is the "no dependency" marker.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_Drive_1  in  1  request valid from issue stage.
- o_Free_1  out  1  responder ready for a new request.
- i_DepL_4  in  TAG_W  left operand dependency tag.
- i_DepR_4  in  TAG_W  right operand dependency tag.
- o_DriveL_1  out  1  left operand valid.
- i_FreeL_1  in  1  left operand consumed.
- o_DataL_32  out  DATA_W  left operand.
- o_DriveR_1  out  1  right operand valid.
- i_FreeR_1  in  1  right operand consumed.
- o_DataR_32  out  DATA_W  right operand.
- i_AllocValid_1  in  1  new producer issued; invalidate its tag.
- i_AllocTag_4  in  TAG_W  tag being allocated.
- i_WbValid_1  in  1  ALU writeback valid.
- i_WbTag_4  in  TAG_W  writeback tag.
- i_WbData_32  in  DATA_W  writeback result.
- i_Flush_1  in  1  pipeline flush.

Behaviour:

Reset:
- Clock and reset are decided: one clock (clk); synchronous active-high reset (rst).
- While rst=1: all entry valid bits 0, entry data 0, state IDLE.
- While rst=1: o_Free_1=0, o_DriveL_1=0, o_DriveR_1=0, o_DataL_32=0, o_DataR_32=0.
- First cycle after rst falls: o_Free_1=1.
- rst mid-transaction aborts it with no further drives.

Entry table:
- Alloc of tag t: valid[t] cleared next cycle.
- Writeback of tag t: data[t] written and valid[t] set next cycle.
- Same tag allocated and written back in the same cycle: alloc wins; valid cleared, data not written.
- Alloc or writeback with tag all-ones is ignored.

State machine (IDLE, WAIT, DONE_WAIT):
- IDLE:
  - o_Free_1=1.
  - When i_Drive_1 is high, latch DepL/DepR and go to WAIT.
  - A side whose tag is all-ones is marked done at accept.
  - If both tags are all-ones, stay in IDLE and generate no drives.
- WAIT, per side, independently:
  - If not done and its entry is valid, load the response register from the entry and assert that side's drive next cycle.
  - Drive stays asserted and data stays held until the matching i_Free is sampled high. That side is then done and its drive drops the next cycle.
  - Data is frozen while driven; later writebacks to the same tag do not alter it.
- When both sides are done, go to IDLE (o_Free_1=1 that cycle).
- o_Free_1=0 in WAIT.
- Latency, entry already valid at accept (cycle N): drive high at N+1.
- Both sides valid: drives assert in the same cycle. Frees may arrive in any order or together.
- DepL == DepR (not all-ones): both sides return the same data, each with its own handshake.

Flush (i_Flush_1):
- Next cycle: all valid bits 0, state IDLE, both drives 0.
- A flush in the same cycle as an accept wins; the request is dropped.
- A flush in the same cycle as a writeback wins; the entry stays invalid.

Optional Feature:
- Macro: ALU_BYPASS_WB_FORWARD_EN.
- Defined: a waiting side whose tag matches this cycle's i_WbTag_4 (with i_WbValid_1 high) loads i_WbData_32 directly; drive rises at M+1 for a writeback at cycle M.
- The forward is also used at accept (cycle N) if writeback to the requested tag coincides.
- Forwarding is suppressed if an alloc to the same tag coincides.
- Undefined: the side waits for the table update; drive rises at M+2.

Test Plan:
- Reset, then no stimulus -> o_Free_1=1, both drives 0, data 0; request DepL=3 stays waiting (no drive) since entry invalid.
- Writeback tag 3 = 0xDEADBEEF, tag 5 = 0x12345678; request DepL=3, DepR=5 at cycle N -> both drives at N+1 with those values; FreeL at N+2, FreeR at N+4 -> drives drop at N+3 and N+5 respectively, o_Free_1=1 at N+5.
- Request DepL=7, DepR=4'b1111 with entry 7 allocated (invalid); writeback tag 7 = 0xA5A5A5A5 at cycle M -> only o_DriveL_1 rises, at M+1 with macro and M+2 without; o_DriveR_1 never rises.
- While o_DriveL_1 is held (free low), writeback tag 3 = 0x1 -> o_DataL_32 stays 0xDEADBEEF until free.
- Alloc and writeback tag 9 in the same cycle -> valid[9]=0; a request DepL=9 gets no drive.
- Both tags all-ones -> no drives, o_Free_1 stays 1.
- Flush asserted during WAIT -> IDLE next cycle, all entries invalid.
- rst pulsed during WAIT -> all outputs at reset values.
